// File: rtl/message_entry_buffer_pkg.sv
// Shared definitions for the message display: character codes, blank pattern,
// and the key synchronizer / press-detect helpers.
package message_entry_buffer_pkg;

  typedef logic [2:0] char_code_t;

  localparam char_code_t CH_H     = 3'd0;
  localparam char_code_t CH_E     = 3'd1;
  localparam char_code_t CH_L     = 3'd2;
  localparam char_code_t CH_O     = 3'd3;
  localparam char_code_t CH_BLANK = 3'd4;
  localparam char_code_t CH_P     = 3'd5;
  localparam char_code_t CH_U     = 3'd6;
  localparam char_code_t CH_DASH  = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic sync1;
    logic sync2;
    logic prev;
  } key_sync_t;

  localparam key_sync_t KEY_RELEASED = 3'b111;

  // Shift the raw active-low key through two sync stages and the prev stage.
  function automatic key_sync_t key_sync_next(key_sync_t cur, logic key_n);
    key_sync_t nxt;
    nxt.sync1 = key_n;
    nxt.sync2 = cur.sync1;
    nxt.prev  = cur.sync2;
    return nxt;
  endfunction

  // One-cycle press pulse on the synchronized high-to-low transition.
  function automatic logic key_pulse(key_sync_t cur);
    return cur.prev & ~cur.sync2;
  endfunction

endpackage

// File: rtl/message_entry_buffer_char_to_seg7.sv
// Combinational 3-bit character code to active-low 7-segment pattern (a..g).
module char_to_seg7
  import message_entry_buffer_pkg::*;
(
  input  logic [2:0] code,
  output logic [0:6] seg
);

  // Character lookup; unknown codes fall back to blank.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CH_H:     seg = 7'b1001000;
      CH_E:     seg = 7'b0110000;
      CH_L:     seg = 7'b1110001;
      CH_O:     seg = 7'b0000001;
      CH_BLANK: seg = 7'b1111111;
      CH_P:     seg = 7'b0011000;
      CH_U:     seg = 7'b1000001;
      CH_DASH:  seg = 7'b1111110;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/message_entry_buffer.sv
// Message composer: append/delete characters from pushbuttons and serve
// registered 7-segment patterns to the scroller.
module message_entry_buffer
  import message_entry_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLOCK_50,
  input  logic          Reset,
  input  logic [2:0]    CharSel,
  input  logic          KeyWr_n,
  input  logic          KeyDel_n,
  input  logic [AW-1:0] RdAddr,
  output logic [0:6]    RdSeg,
  output logic [AW:0]   Length,
  output logic          Full,
  output logic          Empty
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_L  = (AW+1)'(0);

  key_sync_t       wr_key_r;
  key_sync_t       del_key_r;
  logic [AW:0]     length_r;
  char_code_t      mem_r [DEPTH];
  logic [0:6]      rd_seg_r;

  logic            wr_pulse_s;
  logic            del_pulse_s;
  logic            do_app_s;
  logic            do_del_s;
  logic            full_s;
  logic            empty_s;
  logic [AW:0]     length_nxt_s;
  logic [AW-1:0]   wr_idx_s;
  char_code_t      wr_code_s;
  logic [AW:0]     len_dec_s;
  char_code_t      rd_code_s;
  logic [0:6]      rd_seg_s;
  logic            rd_blank_s;

  assign full_s      = (length_r == DEPTH_L);
  assign empty_s     = (length_r == ZERO_L);
  assign wr_pulse_s  = key_pulse(wr_key_r);
  assign del_pulse_s = key_pulse(del_key_r);
  assign len_dec_s   = length_r - ONE_L;
  assign rd_code_s   = mem_r[RdAddr];
  assign rd_blank_s  = ({1'b0, RdAddr} >= length_r);

  char_to_seg7 u_char_to_seg7 (
    .code (rd_code_s),
    .seg  (rd_seg_s)
  );

  // Edit decision: delete beats a simultaneous append; full/empty gate each.
  always_comb begin
    do_app_s     = 1'b0;
    do_del_s     = 1'b0;
    length_nxt_s = length_r;
    wr_idx_s     = length_r[AW-1:0];
    wr_code_s    = CharSel;
    if (del_pulse_s && !empty_s) begin
      do_del_s     = 1'b1;
      length_nxt_s = len_dec_s;
      wr_idx_s     = len_dec_s[AW-1:0];
      wr_code_s    = CH_BLANK;
    end else if (wr_pulse_s && !del_pulse_s && !full_s) begin
      do_app_s     = 1'b1;
      length_nxt_s = length_r + ONE_L;
    end else begin
      do_app_s     = 1'b0;
      do_del_s     = 1'b0;
    end
  end

  // Key synchronizers, length counter and character storage.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      wr_key_r  <= KEY_RELEASED;
      del_key_r <= KEY_RELEASED;
      length_r  <= ZERO_L;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= CH_BLANK;
      end
    end else begin
      wr_key_r  <= key_sync_next(wr_key_r, KeyWr_n);
      del_key_r <= key_sync_next(del_key_r, KeyDel_n);
      length_r  <= length_nxt_s;
      if (do_app_s || do_del_s) begin
        mem_r[wr_idx_s] <= wr_code_s;
      end
    end
  end

  // Registered read port; slots at or beyond Length always read blank.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      rd_seg_r <= SEG_BLANK;
    end else if (rd_blank_s) begin
      rd_seg_r <= SEG_BLANK;
    end else begin
      rd_seg_r <= rd_seg_s;
    end
  end

  assign RdSeg  = rd_seg_r;
  assign Length = length_r;
  assign Full   = full_s;
  assign Empty  = empty_s;

endmodule

// File: doc/message_entry_buffer.md
Name: message_entry_buffer

Overview:
- Writer side of the scrolling 7-segment message display: the user composes a message one character at a time and the scroller reads it back.
- The user picks a character code on switches and presses a key to append it, or presses another key to delete the last character.
- Stores up to DEPTH 3-bit character codes and returns the active-low 7-segment pattern for any slot on a registered read port.
- The scroller steps RdAddr through 0..Length-1 on each scroll tick.

Parameters:
- DEPTH, 8, maximum message length in characters (power of 2, 2..16).
- AW, 3, address width, equal to log2(DEPTH).

Ports:
- CLOCK_50  in  1  system clock; all logic runs on its rising edge.
- Reset  in  1  synchronous, active-high; clears the buffer.
- CharSel  in  3  character code to append (SW-driven, assumed stable while the key is held).
- KeyWr_n  in  1  append pushbutton, active-low, asynchronous to the clock.
- KeyDel_n  in  1  delete-last pushbutton, active-low, asynchronous.
- RdAddr  in  AW  read slot index.
- RdSeg  out  7  [0:6] = segments a..g, active-low, for slot RdAddr.
- Length  out  AW+1  number of stored characters, 0..DEPTH.
- Full  out  1  Length == DEPTH.
- Empty  out  1  Length == 0.

Behaviour:
- Reset, sampled at a clock edge while high:
  - Length=0, Empty=1, Full=0, RdSeg=7'b1111111.
  - All storage slots set to code 4 (blank).
  - Key synchronizers and previous-state flops set to 1 (released).
  - Reset takes priority over any key event in the same cycle.
- Key sampling:
  - Each key passes through a 2-flop synchronizer, then a "prev" flop.
  - A press pulse is generated for one cycle when prev==1 and sync==0.
  - Holding a key produces exactly one pulse; no debounce is required (the bench drives clean edges).
- Latency: a key falling edge at cycle N gives a pulse at N+2, and Length/storage update at edge N+3.
- Append pulse:
  - If not Full: mem[Length] <= CharSel; Length <= Length+1.
  - If Full: ignored; storage and Length unchanged.
- Delete pulse:
  - If not Empty: Length <= Length-1; mem[Length-1] <= 4 (blank).
  - If Empty: ignored.
- Simultaneous append and delete pulses in the same cycle: delete wins; the append is discarded.
- Read port:
  - RdSeg registered, 1-cycle latency: RdSeg at edge k+1 = encode(mem[RdAddr] at edge k).
  - RdAddr >= Length returns blank (1111111), even though the slot holds blank already.
  - A write to slot RdAddr in cycle k is visible on RdSeg at k+2.
- Character encoding (active-low, order a..g):
  - 0 H=1001000; 1 E=0110000; 2 L=1110001; 3 O=0000001.
  - 4 blank=1111111; 5 P=0011000; 6 U=1000001; 7 dash=1111110.
- Full and Empty are combinational from Length.

Decomposition:
- Shared package:
  - char-code constants: CH_H=0, CH_E=1, CH_L=2, CH_O=3, CH_BLANK=4, CH_P=5, CH_U=6, CH_DASH=7.
  - SEG_BLANK=7'b1111111.
- Sub-module: char_to_seg7, combinational 3-bit code to 7-bit pattern.
  - Reused by the scroller and by this block's read path.
- Key synchronizer/edge detector stays inline; it is instantiated twice, so it may be a small local function or generate block.

Test Plan:
- Reset then append H,E,L,L,O (codes 0,1,2,2,3):
  - Length=5; RdAddr=0..4 yields 1001000, 0110000, 1110001, 1110001, 0000001.
  - RdAddr=5 yields 1111111.
- Append 9 characters with DEPTH=8: Length saturates at 8, Full=1, slot 7 holds the 8th code, and the 9th press changes nothing.
- Delete on an empty buffer: Length stays 0, Empty=1. Append E then delete: Length=0, and RdAddr=0 gives 1111111.
- Hold KeyWr_n low for 100 cycles: exactly one append; Length goes from 0 to 1 at edge N+3 after the falling edge.
- Both keys fall in the same cycle with Length=3: Length=2, slot 2 blank, nothing appended.
- Assert Reset for one cycle in the same cycle as an append pulse with Length=4: Length=0, all reads blank, and no append occurs afterwards.
